// File: rtl/cv32e40px_rf_wb_arbiter.sv
// Round-robin write-back arbiter for register-file write port B.
// Selects one producer per cycle, drops illegal pair writes, and registers the write into a single output stage.
module cv32e40px_rf_wb_arbiter #(
  parameter int NUM_REQ     = 3,
  parameter int ADDR_WIDTH  = 6,
  parameter int DATA_WIDTH  = 32,
  parameter int X_DUALWRITE = 1
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     stall_i,
  input  logic [NUM_REQ-1:0]                       req_valid_i,
  output logic [NUM_REQ-1:0]                       req_ready_o,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]       req_addr_i,
  input  logic [NUM_REQ-1:0]                       req_dual_i,
  input  logic [NUM_REQ-1:0][1:0][DATA_WIDTH-1:0]  req_data_i,
  output logic [ADDR_WIDTH-1:0]                    waddr_b_o,
  output logic [1:0][DATA_WIDTH-1:0]               wdata_b_o,
  output logic [1:0]                               we_b_o,
  output logic [2**ADDR_WIDTH-1:0]                 pending_o,
  output logic                                     err_o
);

  localparam int PTR_W  = $clog2(NUM_REQ);
  localparam int FP_BIT = 5;

  logic [PTR_W-1:0]             ptr;
  logic                         gnt_valid;
  logic [PTR_W-1:0]             gnt_idx;
  logic [ADDR_WIDTH-1:0]        sel_addr;
  logic                         sel_dual;
  logic [1:0][DATA_WIDTH-1:0]   sel_data;
  logic                         dual_ok;
  logic [1:0]                   nxt_we;
  logic                         nxt_err;

  // Scan downward so the requester closest to ptr is the last (winning) assignment.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      automatic int idx = (int'(ptr) + k) % NUM_REQ;
      if (req_valid_i[idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = PTR_W'(idx);
      end
    end
    if (stall_i || rst) gnt_valid = 1'b0;
  end

  always_comb begin
    req_ready_o = '0;
    if (gnt_valid) req_ready_o[gnt_idx] = 1'b1;
  end

  assign sel_addr = req_addr_i[gnt_idx];
  assign sel_dual = req_dual_i[gnt_idx];
  assign sel_data = req_data_i[gnt_idx];

  // The register file pairs even/odd integer registers only; x0 can never be a pair base.
  assign dual_ok = (X_DUALWRITE != 0) && !sel_addr[FP_BIT] && !sel_addr[0] && (sel_addr != '0);

  always_comb begin
    nxt_we  = 2'b00;
    nxt_err = 1'b0;
    if (sel_dual) begin
      if (dual_ok) nxt_we  = 2'b11;
      else         nxt_err = 1'b1;
    end else if (sel_addr != '0) begin
      nxt_we = 2'b01;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr       <= '0;
      we_b_o    <= 2'b00;
      waddr_b_o <= '0;
      wdata_b_o <= '0;
      err_o     <= 1'b0;
    end else begin
      we_b_o <= 2'b00;
      err_o  <= 1'b0;
      if (gnt_valid) begin
        we_b_o    <= nxt_we;
        err_o     <= nxt_err;
        waddr_b_o <= sel_addr;
        wdata_b_o <= sel_data;
        ptr       <= (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
      end
    end
  end

  always_comb begin
    pending_o = '0;
    if (we_b_o[0]) pending_o[waddr_b_o]        = 1'b1;
    if (we_b_o[1]) pending_o[waddr_b_o + 1'b1] = 1'b1;
  end

endmodule

// File: tb/tb_cv32e40px_rf_wb_arbiter.sv
// Bench for cv32e40px_rf_wb_arbiter: directed scenarios plus randomized traffic against a round-robin model.
module tb_cv32e40px_rf_wb_arbiter;
  localparam int N  = 3;
  localparam int AW = 6;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst;
  logic stall;
  logic [N-1:0]                 valid, dual;
  logic [N-1:0][AW-1:0]         addr;
  logic [N-1:0][1:0][DW-1:0]    data;

  logic [N-1:0]        ready0, ready1;
  logic [AW-1:0]       waddr0, waddr1;
  logic [1:0][DW-1:0]  wdata0, wdata1;
  logic [1:0]          we0, we1;
  logic [63:0]         pend0, pend1;
  logic                err0, err1;

  int checks = 0;
  int errors = 0;

  int                 m_ptr;
  int                 g;
  logic [N-1:0]       exp_ready;
  logic [1:0]         exp_we, exp_we1;
  logic               exp_err, exp_err1;
  logic [AW-1:0]      exp_addr;
  logic [1:0][DW-1:0] exp_data;
  logic [63:0]        exp_pend;

  always #5 clk = ~clk;

  cv32e40px_rf_wb_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .X_DUALWRITE(1)) dut (
    .clk(clk), .rst(rst), .stall_i(stall), .req_valid_i(valid), .req_ready_o(ready0),
    .req_addr_i(addr), .req_dual_i(dual), .req_data_i(data), .waddr_b_o(waddr0),
    .wdata_b_o(wdata0), .we_b_o(we0), .pending_o(pend0), .err_o(err0));

  cv32e40px_rf_wb_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .X_DUALWRITE(0)) dut_nodual (
    .clk(clk), .rst(rst), .stall_i(stall), .req_valid_i(valid), .req_ready_o(ready1),
    .req_addr_i(addr), .req_dual_i(dual), .req_data_i(data), .waddr_b_o(waddr1),
    .wdata_b_o(wdata1), .we_b_o(we1), .pending_o(pend1), .err_o(err1));

  // Reference write-enable from the legality rules, using plain integer arithmetic.
  function automatic logic [1:0] model_we(input int a, input bit is_dual, input bit xdw);
    if (!is_dual) return (a == 0) ? 2'b00 : 2'b01;
    if (xdw && a < 32 && a % 2 == 0 && a != 0) return 2'b11;
    return 2'b00;
  endfunction

  task automatic predict();
    int a;
    #1;
    g = -1;
    if (!stall && !rst)
      for (int k = 0; k < N; k++)
        if (g < 0 && valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
    exp_ready = '0;
    exp_we = 2'b00; exp_we1 = 2'b00; exp_err = 1'b0; exp_err1 = 1'b0; exp_pend = '0;
    if (g >= 0) begin
      exp_ready[g] = 1'b1;
      a = int'(addr[g]);
      exp_we   = model_we(a, dual[g], 1'b1);
      exp_we1  = model_we(a, dual[g], 1'b0);
      exp_err  = dual[g] && exp_we == 2'b00;
      exp_err1 = dual[g] && exp_we1 == 2'b00;
      exp_addr = addr[g];
      exp_data = data[g];
      if (exp_we[0]) exp_pend[a] = 1'b1;
      if (exp_we[1]) exp_pend[a + 1] = 1'b1;
    end
  endtask

  task automatic advance();
    @(posedge clk);
    if (g >= 0) m_ptr = (g + 1) % N;
    #1;
  endtask

  task automatic set_req(input int i, input int a, input bit d, input logic [DW-1:0] w0, input logic [DW-1:0] w1);
    valid[i] = 1'b1; addr[i] = AW'(a); dual[i] = d; data[i][0] = w0; data[i][1] = w1;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; valid = '0; dual = '0; addr = '0; data = '0;
    m_ptr = 0;
    repeat (2) @(posedge clk);
    set_req(0, 5, 1'b0, 32'h1234_5678, 32'h0);
    #1;
    checks++;
    if (ready0 !== 3'b000) begin errors++; $display("FAIL reset_ready: got %b expected 000", ready0); end
    checks++;
    if (we0 !== 2'b00 || waddr0 !== '0 || wdata0 !== '0 || pend0 !== '0 || err0 !== 1'b0) begin
      errors++; $display("FAIL reset_outputs: we=%b waddr=%h pend=%h err=%b expected all zero", we0, waddr0, pend0, err0);
    end
    valid = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single();
    set_req(0, 5, 1'b0, 32'hDEAD_BEEF, 32'hFFFF_FFFF);
    predict();
    checks++;
    if (ready0 !== 3'b001) begin errors++; $display("FAIL single_ready: got %b expected 001", ready0); end
    advance();
    valid = '0;
    checks++;
    if (we0 !== 2'b01 || waddr0 !== 6'd5 || wdata0[0] !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL single_write: we=%b waddr=%0d w0=%h expected 01/5/deadbeef", we0, waddr0, wdata0[0]);
    end
    checks++;
    if (pend0 !== 64'h20) begin errors++; $display("FAIL single_pending: got %h expected 20", pend0); end
    predict();
    advance();
    checks++;
    if (pend0 !== '0 || we0 !== 2'b00) begin errors++; $display("FAIL single_clear: pend=%h we=%b expected 0/00", pend0, we0); end
  endtask

  task automatic test_round_robin();
    int start;
    start = m_ptr;
    set_req(0, 3, 1'b0, 32'hA0A0_0003, 32'h0);
    set_req(1, 4, 1'b0, 32'hA1A1_0004, 32'h0);
    set_req(2, 6, 1'b0, 32'hA2A2_0006, 32'h0);
    for (int c = 0; c < 6; c++) begin
      predict();
      checks++;
      if (g != (start + c) % N || ready0 !== exp_ready) begin
        errors++; $display("FAIL rr_grant%0d: got %b expected grant %0d", c, ready0, (start + c) % N);
      end
      advance();
      checks++;
      if (we0 !== 2'b01 || waddr0 !== exp_addr || wdata0[0] !== exp_data[0] || pend0 !== exp_pend) begin
        errors++; $display("FAIL rr_write%0d: we=%b waddr=%0d pend=%h expected 01/%0d/%h", c, we0, waddr0, pend0, exp_addr, exp_pend);
      end
    end
    valid = '0;
    predict();
    advance();
  endtask

  task automatic test_dual();
    set_req(2, 10, 1'b1, 32'h1111_1111, 32'h2222_2222);
    predict();
    checks++;
    if (ready0 !== exp_ready || ready0 === 3'b000) begin errors++; $display("FAIL dual_ready: got %b expected %b", ready0, exp_ready); end
    while (g != 2) begin
      advance();
      predict();
    end
    advance();
    valid = '0;
    checks++;
    if (we0 !== 2'b11 || waddr0 !== 6'd10 || wdata0[0] !== 32'h1111_1111 || wdata0[1] !== 32'h2222_2222) begin
      errors++; $display("FAIL dual_write: we=%b waddr=%0d w0=%h w1=%h expected 11/10/11111111/22222222", we0, waddr0, wdata0[0], wdata0[1]);
    end
    checks++;
    if (pend0 !== 64'hC00 || err0 !== 1'b0) begin errors++; $display("FAIL dual_pending: pend=%h err=%b expected c00/0", pend0, err0); end
    checks++;
    if (we1 !== 2'b00 || err1 !== 1'b1 || pend1 !== '0) begin
      errors++; $display("FAIL nodual_drop: we=%b err=%b pend=%h expected 00/1/0", we1, err1, pend1);
    end
    predict();
    advance();
  endtask

  task automatic test_illegal();
    int bad_addr [3] = '{0, 7, 34};
    for (int k = 0; k < 4; k++) begin
      if (k < 3) set_req(1, bad_addr[k], 1'b1, 32'hBAD0_0000 + k, 32'hBAD1_0000 + k);
      else       set_req(1, 0, 1'b0, 32'hCAFE_0000, 32'h0);
      predict();
      while (g != 1) begin
        advance();
        predict();
      end
      advance();
      valid = '0;
      checks++;
      if (we0 !== 2'b00 || pend0 !== '0 || err0 !== (k < 3)) begin
        errors++; $display("FAIL illegal%0d: we=%b pend=%h err=%b expected 00/0/%0d", k, we0, pend0, err0, k < 3);
      end
      predict();
      advance();
      checks++;
      if (err0 !== 1'b0) begin errors++; $display("FAIL illegal_pulse%0d: err=%b expected 0", k, err0); end
    end
  endtask

  task automatic test_stall();
    set_req(0, 12, 1'b0, 32'h5555_000C, 32'h0);
    predict();
    while (g != 0) begin
      advance();
      predict();
    end
    advance();
    valid = '0;
    set_req(1, 13, 1'b0, 32'h6666_000D, 32'h0);
    stall = 1'b1;
    checks++;
    if (we0 !== 2'b01 || waddr0 !== 6'd12) begin errors++; $display("FAIL stall_inflight: we=%b waddr=%0d expected 01/12", we0, waddr0); end
    for (int c = 0; c < 3; c++) begin
      predict();
      checks++;
      if (ready0 !== 3'b000 || ready1 !== 3'b000) begin errors++; $display("FAIL stall_ready%0d: got %b expected 000", c, ready0); end
      advance();
      checks++;
      if (we0 !== 2'b00) begin errors++; $display("FAIL stall_we%0d: got %b expected 00", c, we0); end
    end
    stall = 1'b0;
    predict();
    checks++;
    if (ready0 !== 3'b010) begin errors++; $display("FAIL stall_release: got %b expected 010", ready0); end
    advance();
    valid = '0;
    checks++;
    if (we0 !== 2'b01 || waddr0 !== 6'd13) begin errors++; $display("FAIL stall_after: we=%b waddr=%0d expected 01/13", we0, waddr0); end
  endtask

  task automatic test_reset_mid();
    set_req(1, 9, 1'b0, 32'h7777_0009, 32'h0);
    predict();
    while (g != 1) begin
      advance();
      predict();
    end
    advance();
    valid = '0;
    rst = 1'b1;
    #1;
    checks++;
    if (we0 !== 2'b00 || pend0 !== '0 || ready0 !== '0) begin
      errors++; $display("FAIL midreset_clear: we=%b pend=%h ready=%b expected zeros", we0, pend0, ready0);
    end
    @(negedge clk);
    rst = 1'b0;
    m_ptr = 0;
    set_req(0, 1, 1'b0, 32'h1, 32'h0);
    set_req(1, 2, 1'b0, 32'h2, 32'h0);
    set_req(2, 3, 1'b0, 32'h3, 32'h0);
    predict();
    checks++;
    if (ready0 !== 3'b001) begin errors++; $display("FAIL midreset_ptr: got %b expected 001", ready0); end
    advance();
    valid = '0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++)
        if (!valid[i] && $urandom_range(0, 1) == 1)
          set_req(i, $urandom_range(0, 63), $urandom_range(0, 2) == 0, $urandom, $urandom);
      stall = ($urandom_range(0, 4) == 0);
      predict();
      checks++;
      if (ready0 !== exp_ready || ready1 !== exp_ready) begin
        errors++; $display("FAIL rand_ready%0d: got %b/%b expected %b", c, ready0, ready1, exp_ready);
      end
      advance();
      if (g >= 0) valid[g] = 1'b0;
      checks++;
      if (we0 !== exp_we || err0 !== exp_err || pend0 !== exp_pend || we1 !== exp_we1 || err1 !== exp_err1) begin
        errors++; $display("FAIL rand_out%0d: we=%b err=%b pend=%h we1=%b err1=%b expected %b/%b/%h/%b/%b",
                           c, we0, err0, pend0, we1, err1, exp_we, exp_err, exp_pend, exp_we1, exp_err1);
      end
      if (exp_we != 2'b00) begin
        checks++;
        if (waddr0 !== exp_addr || wdata0[0] !== exp_data[0] || (exp_we[1] && wdata0[1] !== exp_data[1])) begin
          errors++; $display("FAIL rand_data%0d: waddr=%0d w0=%h w1=%h expected %0d/%h/%h",
                             c, waddr0, wdata0[0], wdata0[1], exp_addr, exp_data[0], exp_data[1]);
        end
      end
    end
    stall = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_dual();
    test_illegal();
    test_stall();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
